// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings and frame geometry,
// common to the receiver and the 8N1 transmitter.
package uart_pkg;

    localparam int DATA_BITS = 8;
    localparam int IDX_W     = $clog2(DATA_BITS);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

endpackage

// File: rtl/uart_sync.sv
// Multi-stage metastability synchroniser for the asynchronous RX pin.
// Flops reset to 1 so the line reads idle out of reset.
module uart_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_in,
    output logic d_out
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d_in};
    end

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign d_out = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver: centre-sampling FSM with framing-error and overrun
// reporting, plus a pending/ack handshake towards the host.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 data_pending,
    input  logic                 data_ack,
    output logic                 busy
);

    localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_M1   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    logic                 rx_s;
    logic [1:0]           state_q,    state_d;
    logic [CNT_W-1:0]     baud_cnt_q, baud_cnt_d;
    logic [IDX_W-1:0]     index_q,    index_d;
    logic [DATA_BITS-1:0] shift_q,    shift_d;
    logic [DATA_BITS-1:0] data_out_q, data_out_d;
    logic                 valid_q,    valid_d;
    logic                 ferr_q,     ferr_d;
    logic                 overrun_q,  overrun_d;
    logic                 pending_q,  pending_d;
    logic                 busy_q,     busy_d;

    uart_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_in  (rx_in),
        .d_out (rx_s)
    );

    always_comb begin
        // NOTE: every signal gets a default first, so no path can infer a latch.
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        index_d    = index_q;
        shift_d    = shift_q;
        data_out_d = data_out_q;
        valid_d    = 1'b0;
        ferr_d     = 1'b0;

        case (state_q)
            IDLE: begin
                baud_cnt_d = '0;
                if (!rx_s) state_d = START;
            end
            START: begin
                if (baud_cnt_q == HALF_M1) begin
                    baud_cnt_d = '0;
                    index_d    = '0;
                    state_d    = rx_s ? IDLE : DATA;
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (baud_cnt_q == BIT_M1) begin
                    baud_cnt_d       = '0;
                    shift_d[index_q] = rx_s;
                    if (index_q == IDX_LAST) state_d = STOP;
                    else                     index_d = index_q + 1'b1;
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            STOP: begin
                // Leave at mid-stop so the next start edge may arrive half a bit early.
                if (baud_cnt_q == BIT_M1) begin
                    baud_cnt_d = '0;
                    state_d    = IDLE;
                    if (rx_s) begin
                        data_out_d = shift_q;
                        valid_d    = 1'b1;
                    end else begin
                        ferr_d     = 1'b1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // An ack landing on the strobe cycle retires the previous byte only.
        pending_d = valid_q ? 1'b1 : (data_ack ? 1'b0 : pending_q);
        if (data_ack)                  overrun_d = 1'b0;
        else if (valid_q && pending_q) overrun_d = 1'b1;
        else                           overrun_d = overrun_q;

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            baud_cnt_q <= '0;
            index_q    <= '0;
            shift_q    <= '0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
            overrun_q  <= 1'b0;
            pending_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            index_q    <= index_d;
            shift_q    <= shift_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
            overrun_q  <= overrun_d;
            pending_q  <= pending_d;
            busy_q     <= busy_d;
        end
    end

    assign data_out     = data_out_q;
    assign data_valid   = valid_q;
    assign frame_err    = ferr_q;
    assign overrun      = overrun_q;
    assign data_pending = pending_q | valid_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit: good frames, back-to-back,
// glitch rejection, framing error, overrun handshake and mid-frame reset.
module tb_uart_rx;

    localparam int CPB  = 16;
    localparam int SYNC = 2;
    localparam int HALF = CPB / 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_in = 1'b1;
    logic       data_ack = 1'b0;
    logic [7:0] data_out;
    logic       data_valid, frame_err, overrun, data_pending, busy;

    int vectors = 0;
    int miscompares = 0;
    int valid_cnt = 0;
    int ferr_cnt = 0;
    int both_cnt = 0;
    logic [7:0] last_byte = 8'h00;
    logic [7:0] byte_log [0:15];

    uart_rx #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(SYNC)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_in        (rx_in),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .frame_err    (frame_err),
        .overrun      (overrun),
        .data_pending (data_pending),
        .data_ack     (data_ack),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (data_valid) begin
            if (valid_cnt < 16) byte_log[valid_cnt] = data_out;
            last_byte = data_out;
            valid_cnt = valid_cnt + 1;
        end
        if (frame_err) ferr_cnt = ferr_cnt + 1;
        if (data_valid && frame_err) both_cnt = both_cnt + 1;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic v);
        rx_in = v;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_bit);
        rx_in = 1'b1;
    endtask

    task automatic pulse_ack();
        data_ack = 1'b1;
        @(posedge clk);
        #1 data_ack = 1'b0;
    endtask

    task automatic idle_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Raise data_ack in the very cycle data_valid is visible.
    task automatic ack_on_valid();
        bit seen = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (data_valid) seen = 1;
        end
        check("coincident_ack_window", 32'(seen), 32'd1);
        data_ack = 1'b1;
        @(posedge clk);
        #1 data_ack = 1'b0;
    endtask

    initial begin
        bit returned;

        // Reset state
        #12;
        check("rst_data_out", 32'(data_out), 32'h00);
        check("rst_valid", 32'(data_valid), 32'd0);
        check("rst_pending", 32'(data_pending), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle_clks(4);

        // 1: single good byte
        send_byte(8'hA5, 1'b1);
        check("t1_valid_cnt", 32'(valid_cnt), 32'd1);
        check("t1_data", 32'(data_out), 32'hA5);
        check("t1_ferr_cnt", 32'(ferr_cnt), 32'd0);
        check("t1_pending", 32'(data_pending), 32'd1);
        check("t1_busy", 32'(busy), 32'd0);
        pulse_ack();
        check("t1_pending_acked", 32'(data_pending), 32'd0);

        // 2: back-to-back frames with acks
        send_byte(8'h3C, 1'b1);
        fork
            send_byte(8'hFF, 1'b1);
            pulse_ack();
        join
        pulse_ack();
        check("t2_valid_cnt", 32'(valid_cnt), 32'd3);
        check("t2_byte0", 32'(byte_log[1]), 32'h3C);
        check("t2_byte1", 32'(byte_log[2]), 32'hFF);
        check("t2_overrun", 32'(overrun), 32'd0);
        idle_clks(CPB);

        // 3: short glitch on idle line
        rx_in = 1'b0;
        idle_clks(3);
        rx_in = 1'b1;
        check("t3_busy_on_glitch", 32'(busy), 32'd1);
        returned = 0;
        for (int i = 0; i < HALF + SYNC + 4 && !returned; i++) begin
            @(negedge clk);
            if (!busy) returned = 1;
        end
        check("t3_busy_returns", 32'(returned), 32'd1);
        idle_clks(CPB);
        check("t3_valid_cnt", 32'(valid_cnt), 32'd3);
        check("t3_ferr_cnt", 32'(ferr_cnt), 32'd0);

        // 4: framing error, then a clean byte
        send_byte(8'h55, 1'b0);
        idle_clks(3 * CPB);
        check("t4_ferr_cnt", 32'(ferr_cnt), 32'd1);
        check("t4_valid_cnt", 32'(valid_cnt), 32'd3);
        check("t4_data_kept", 32'(data_out), 32'hFF);
        check("t4_busy_idle", 32'(busy), 32'd0);
        send_byte(8'h12, 1'b1);
        check("t4_valid_after", 32'(valid_cnt), 32'd4);
        check("t4_data_12", 32'(data_out), 32'h12);
        pulse_ack();

        // 5a: overrun without ack, then clear it
        send_byte(8'h01, 1'b1);
        check("t5_pending_1", 32'(data_pending), 32'd1);
        check("t5_overrun_pre", 32'(overrun), 32'd0);
        send_byte(8'h02, 1'b1);
        check("t5_overrun_set", 32'(overrun), 32'd1);
        check("t5_data_02", 32'(data_out), 32'h02);
        pulse_ack();
        check("t5_overrun_clr", 32'(overrun), 32'd0);
        check("t5_pending_clr", 32'(data_pending), 32'd0);

        // 5b: ack coincident with the second strobe
        send_byte(8'h01, 1'b1);
        fork
            send_byte(8'h02, 1'b1);
            ack_on_valid();
        join
        check("t5b_overrun", 32'(overrun), 32'd0);
        check("t5b_pending", 32'(data_pending), 32'd1);
        check("t5b_valid_cnt", 32'(valid_cnt), 32'd8);
        idle_clks(CPB);

        // 6: reset during data bit 4
        fork
            send_byte(8'hC3, 1'b1);
            begin
                repeat (CPB * 5 + HALF) @(posedge clk);
                #1 rst_n = 1'b0;
                #1;
                check("t6_rst_data", 32'(data_out), 32'h00);
                check("t6_rst_valid", 32'(data_valid), 32'd0);
                check("t6_rst_ferr", 32'(frame_err), 32'd0);
                check("t6_rst_overrun", 32'(overrun), 32'd0);
                check("t6_rst_pending", 32'(data_pending), 32'd0);
                check("t6_rst_busy", 32'(busy), 32'd0);
            end
        join
        idle_clks(2);
        rst_n = 1'b1;
        idle_clks(4);
        check("t6_no_strobe", 32'(valid_cnt), 32'd8);
        send_byte(8'hC3, 1'b1);
        check("t6_valid_cnt", 32'(valid_cnt), 32'd9);
        check("t6_data_c3", 32'(last_byte), 32'hC3);
        check("t6_ferr_total", 32'(ferr_cnt), 32'd1);
        check("never_both", 32'(both_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
